// File: rtl/demux_pkg.sv
// Shared types and default sizing for the 1-to-N stream demultiplexer.
package demux_pkg;

  typedef enum logic {
    SEL_EXPLICIT = 1'b0,
    SEL_AUTO     = 1'b1
  } sel_mode_e;

  localparam int DEFAULT_DATA_WIDTH   = 8;
  localparam int DEFAULT_NUM_CHANNELS = 16;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output holding register for a single demux channel.
// A load in the same cycle as a drain replaces the beat with no bubble.
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  drain_ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  free
);

  assign free = !valid || drain_ready;

  // Data is left untouched on a plain drain; only valid matters downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && drain_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1_n_stream.sv
// Valid/ready 1-to-N stream demultiplexer with explicit or auto-sequential select.
// Define DEMUX_AUTO_SEQ_EN to build the auto-sequential pointer; otherwise explicit only.
module demux_1_n_stream
  import demux_pkg::*;
#(
  parameter  int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter  int NUM_CHANNELS = DEFAULT_NUM_CHANNELS,
  localparam int SEL_WIDTH    = $clog2(NUM_CHANNELS)
) (
  input  logic                               Clock_In,
  input  logic                               Reset_In,
  input  logic                               Enable_In,
  input  logic                               Mode_In,
  input  logic [DATA_WIDTH-1:0]              Data_In,
  input  logic                               Valid_In,
  output logic                               Ready_Out,
  input  logic [SEL_WIDTH-1:0]               Select_In,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] Data_Out,
  output logic [NUM_CHANNELS-1:0]            Valid_Out,
  input  logic [NUM_CHANNELS-1:0]            Ready_In,
  output logic                               Error_Out,
  output logic [SEL_WIDTH-1:0]               Seq_Ptr_Out
);

  logic [SEL_WIDTH-1:0]    seq_ptr;
  logic [SEL_WIDTH-1:0]    target;
  logic                    in_range;
  logic                    target_free;
  logic                    accept;
  logic [NUM_CHANNELS-1:0] slot_free;
  logic [NUM_CHANNELS-1:0] load;
  logic                    error_q;

`ifdef DEMUX_AUTO_SEQ_EN
  sel_mode_e mode;

  assign mode   = sel_mode_e'(Mode_In);
  assign target = (mode == SEL_AUTO) ? seq_ptr : Select_In;

  // Pointer only moves on accepted auto-mode beats, so explicit traffic leaves it parked.
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      seq_ptr <= '0;
    end else if (accept && (mode == SEL_AUTO)) begin
      seq_ptr <= (seq_ptr == SEL_WIDTH'(NUM_CHANNELS - 1)) ? '0 : seq_ptr + 1'b1;
    end
  end
`else
  logic unused_mode;

  assign unused_mode = Mode_In;
  assign seq_ptr     = '0;
  assign target      = Select_In;
`endif

  assign Seq_Ptr_Out = seq_ptr;
  assign in_range    = ({1'b0, target} < (SEL_WIDTH + 1)'(NUM_CHANNELS));

  // An out-of-range target matches no slot, so it stays "free" and the beat is swallowed.
  always_comb begin
    target_free = 1'b1;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (target == SEL_WIDTH'(k)) begin
        target_free = slot_free[k];
      end
    end
  end

  assign Ready_Out = Enable_In && !Reset_In && target_free;
  assign accept    = Ready_Out && Valid_In;

  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      error_q <= 1'b0;
    end else begin
      error_q <= accept && !in_range;
    end
  end

  assign Error_Out = error_q;

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_slot
    assign load[k] = accept && (target == SEL_WIDTH'(k));

    demux_out_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk        (Clock_In),
      .reset      (Reset_In),
      .load       (load[k]),
      .load_data  (Data_In),
      .drain_ready(Ready_In[k]),
      .valid      (Valid_Out[k]),
      .data       (Data_Out[k*DATA_WIDTH +: DATA_WIDTH]),
      .free       (slot_free[k])
    );
  end

endmodule

// File: tb/tb_demux_1_n_stream.sv
// Directed bench for demux_1_n_stream: a 16-channel instance driven from a vector
// table plus hand sequences, and a 12-channel instance for out-of-range selects.
module tb_demux_1_n_stream;

  logic         clk;
  logic         rst;
  logic         enable;
  logic         mode;
  logic [7:0]   data_in;
  logic         valid_in;
  logic         ready_out;
  logic [3:0]   select;
  logic [127:0] data_out;
  logic [15:0]  valid_out;
  logic [15:0]  ready_in;
  logic         error_out;
  logic [3:0]   seq_ptr;

  logic         enable12;
  logic         mode12;
  logic [7:0]   data12;
  logic         valid12;
  logic         ready_out12;
  logic [3:0]   select12;
  logic [95:0]  data_out12;
  logic [11:0]  valid_out12;
  logic [11:0]  ready_in12;
  logic         error12;
  logic [3:0]   seq_ptr12;

  int tests_run;
  int tests_failed;

  demux_1_n_stream #(.DATA_WIDTH(8), .NUM_CHANNELS(16)) dut (
    .Clock_In   (clk),
    .Reset_In   (rst),
    .Enable_In  (enable),
    .Mode_In    (mode),
    .Data_In    (data_in),
    .Valid_In   (valid_in),
    .Ready_Out  (ready_out),
    .Select_In  (select),
    .Data_Out   (data_out),
    .Valid_Out  (valid_out),
    .Ready_In   (ready_in),
    .Error_Out  (error_out),
    .Seq_Ptr_Out(seq_ptr)
  );

  demux_1_n_stream #(.DATA_WIDTH(8), .NUM_CHANNELS(12)) dut12 (
    .Clock_In   (clk),
    .Reset_In   (rst),
    .Enable_In  (enable12),
    .Mode_In    (mode12),
    .Data_In    (data12),
    .Valid_In   (valid12),
    .Ready_Out  (ready_out12),
    .Select_In  (select12),
    .Data_Out   (data_out12),
    .Valid_Out  (valid_out12),
    .Ready_In   (ready_in12),
    .Error_Out  (error12),
    .Seq_Ptr_Out(seq_ptr12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic [7:0]  data;
    logic        valid;
    logic        en;
    logic [15:0] rdy;
    logic        exp_ready;
    logic [15:0] exp_vo;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[10];

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] sel, input logic [7:0] d, input logic v,
                                input logic en, input logic [15:0] rdy);
    select   = sel;
    data_in  = d;
    valid_in = v;
    enable   = en;
    ready_in = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst      = 1'b1;
    mode     = 1'b0;
    mode12   = 1'b0;
    enable12 = 1'b1;
    data12   = 8'h00;
    valid12  = 1'b0;
    select12 = 4'd0;
    ready_in12 = '1;

    // Ready must stay low throughout reset even with a beat offered
    apply_stimulus(4'd1, 8'h11, 1'b1, 1'b1, 16'hFFFF);
    tick();
    check_output("reset_ready", 128'(ready_out), 128'(0));
    tick();
    check_output("reset_valid", 128'(valid_out), 128'(0));
    check_output("reset_data", data_out, 128'(0));
    check_output("reset_ptr", 128'(seq_ptr), 128'(0));
    check_output("reset_error", 128'({error_out, error12}), 128'(0));
    check_output("reset_valid12", 128'(valid_out12), 128'(0));
    rst = 1'b0;

    //           sel     data   v     en    rdy        er    exp_vo     exp_data
    vecs[0] = '{4'd5,  8'hA5, 1'b1, 1'b1, 16'hFFFF, 1'b1, 16'h0020, 8'hA5};
    vecs[1] = '{4'd5,  8'h00, 1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h0000, 8'h00};
    vecs[2] = '{4'd0,  8'h3C, 1'b1, 1'b1, 16'hFFFF, 1'b1, 16'h0001, 8'h3C};
    vecs[3] = '{4'd15, 8'hF0, 1'b1, 1'b1, 16'hFFFF, 1'b1, 16'h8000, 8'hF0};
    vecs[4] = '{4'd9,  8'h99, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h8200, 8'h99};
    vecs[5] = '{4'd15, 8'hE1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h8200, 8'hF0};
    vecs[6] = '{4'd15, 8'hE1, 1'b1, 1'b1, 16'h8000, 1'b1, 16'h8200, 8'hE1};
    vecs[7] = '{4'd9,  8'h5A, 1'b1, 1'b0, 16'hFFFF, 1'b0, 16'h0000, 8'h00};
    vecs[8] = '{4'd9,  8'h5A, 1'b1, 1'b1, 16'hFFFF, 1'b1, 16'h0200, 8'h5A};
    vecs[9] = '{4'd0,  8'h00, 1'b0, 1'b1, 16'hFFFF, 1'b1, 16'h0000, 8'h00};

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].sel, vecs[i].data, vecs[i].valid, vecs[i].en, vecs[i].rdy);
      check_output($sformatf("vec%0d_ready", i), 128'(ready_out), 128'(vecs[i].exp_ready));
      tick();
      check_output($sformatf("vec%0d_valid", i), 128'(valid_out), 128'(vecs[i].exp_vo));
      if (vecs[i].exp_vo[vecs[i].sel])
        check_output($sformatf("vec%0d_data", i),
                     128'(data_out[int'(vecs[i].sel)*8 +: 8]), 128'(vecs[i].exp_data));
    end

    // Backpressure on channel 3: second beat waits, then loads as the first drains
    apply_stimulus(4'd3, 8'h31, 1'b1, 1'b1, 16'hFFF7);
    tick();
    check_output("bp_first_valid", 128'(valid_out), 128'(16'h0008));
    apply_stimulus(4'd3, 8'h32, 1'b1, 1'b1, 16'hFFF7);
    check_output("bp_second_blocked", 128'(ready_out), 128'(0));
    tick();
    check_output("bp_first_held", 128'(data_out[3*8 +: 8]), 128'(8'h31));
    apply_stimulus(4'd3, 8'h32, 1'b1, 1'b1, 16'hFFFF);
    check_output("bp_release_ready", 128'(ready_out), 128'(1));
    tick();
    check_output("bp_swap_valid", 128'(valid_out), 128'(16'h0008));
    check_output("bp_swap_data", 128'(data_out[3*8 +: 8]), 128'(8'h32));
    apply_stimulus(4'd3, 8'h00, 1'b0, 1'b1, 16'hFFFF);
    tick();
    check_output("bp_drained", 128'(valid_out), 128'(0));

    // Enable low blocks accepts while a held beat still drains
    apply_stimulus(4'd2, 8'h22, 1'b1, 1'b1, 16'h0000);
    tick();
    apply_stimulus(4'd4, 8'h44, 1'b1, 1'b0, 16'h0000);
    check_output("en_low_ready", 128'(ready_out), 128'(0));
    tick();
    check_output("en_low_no_new", 128'(valid_out), 128'(16'h0004));
    apply_stimulus(4'd4, 8'h44, 1'b1, 1'b0, 16'h0004);
    tick();
    check_output("en_low_drain", 128'(valid_out), 128'(0));

`ifdef DEMUX_AUTO_SEQ_EN
    // Auto mode: 18 beats wrap the pointer past the last channel
    mode = 1'b1;
    for (int i = 0; i < 18; i++) begin
      apply_stimulus(4'd10, 8'(i), 1'b1, 1'b1, 16'hFFFF);
      check_output($sformatf("auto%0d_ptr", i), 128'(seq_ptr), 128'(i % 16));
      tick();
      check_output($sformatf("auto%0d_valid", i), 128'(valid_out), 128'(16'(1) << (i % 16)));
      check_output($sformatf("auto%0d_data", i), 128'(data_out[(i % 16)*8 +: 8]), 128'(i));
    end
    apply_stimulus(4'd0, 8'h00, 1'b0, 1'b1, 16'hFFFF);
    check_output("auto_final_ptr", 128'(seq_ptr), 128'(2));
    mode = 1'b0;
    apply_stimulus(4'd6, 8'h66, 1'b1, 1'b1, 16'hFFFF);
    tick();
    check_output("auto_hold_explicit", 128'(valid_out), 128'(16'h0040));
    check_output("auto_hold_ptr", 128'(seq_ptr), 128'(2));
    mode = 1'b1;
    apply_stimulus(4'd0, 8'h77, 1'b1, 1'b1, 16'hFFFF);
    tick();
    check_output("auto_resume", 128'(valid_out), 128'(16'h0004));
    check_output("auto_resume_ptr", 128'(seq_ptr), 128'(3));
    mode = 1'b0;
`else
    // Without the auto feature, Mode_In is ignored and the pointer reads zero
    mode = 1'b1;
    apply_stimulus(4'd9, 8'h9E, 1'b1, 1'b1, 16'hFFFF);
    tick();
    check_output("mode_ignored_valid", 128'(valid_out), 128'(16'h0200));
    check_output("mode_ignored_data", 128'(data_out[9*8 +: 8]), 128'(8'h9E));
    check_output("mode_ignored_ptr", 128'(seq_ptr), 128'(0));
    mode = 1'b0;
`endif
    apply_stimulus(4'd0, 8'h00, 1'b0, 1'b1, 16'hFFFF);
    tick();

    // Out-of-range select on the 12-channel instance
    select12 = 4'd13; data12 = 8'hD3; valid12 = 1'b1;
    #1;
    check_output("oor_ready", 128'(ready_out12), 128'(1));
    tick();
    check_output("oor_no_valid", 128'(valid_out12), 128'(0));
    check_output("oor_error", 128'(error12), 128'(1));
    valid12 = 1'b0;
    tick();
    check_output("oor_error_clear", 128'(error12), 128'(0));
    select12 = 4'd11; data12 = 8'hB1; valid12 = 1'b1;
    tick();
    check_output("edge11_valid", 128'(valid_out12), 128'(12'h800));
    check_output("edge11_data", 128'(data_out12[11*8 +: 8]), 128'(8'hB1));
    check_output("edge11_error", 128'(error12), 128'(0));
    select12 = 4'd12; data12 = 8'hC0;
    tick();
    check_output("edge12_error", 128'(error12), 128'(1));
    check_output("edge12_no_valid", 128'(valid_out12), 128'(0));
    valid12 = 1'b0;
    tick();

    // Reset while channels 2 and 7 hold beats
    apply_stimulus(4'd2, 8'h22, 1'b1, 1'b1, 16'h0000);
    tick();
    apply_stimulus(4'd7, 8'h77, 1'b1, 1'b1, 16'h0000);
    tick();
    check_output("pre_reset_valid", 128'(valid_out), 128'(16'h0084));
    rst = 1'b1;
    apply_stimulus(4'd3, 8'h33, 1'b1, 1'b1, 16'h0000);
    check_output("in_reset_ready", 128'(ready_out), 128'(0));
    tick();
    check_output("post_reset_valid", 128'(valid_out), 128'(0));
    check_output("post_reset_data", data_out, 128'(0));
    check_output("post_reset_ptr", 128'(seq_ptr), 128'(0));
    rst = 1'b0;
    apply_stimulus(4'd3, 8'h00, 1'b0, 1'b1, 16'h0000);
    tick();
    check_output("post_reset_discard", 128'(valid_out), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
